// File: rtl/sim_cntrl_src_arb.sv
// Registered N-way simulation-control source select with drained, guarded handover; 1-cycle latency.
// No backpressure: a busy old source holds the switch in DRAIN until idle or DRAIN_MAX expires.
module sim_cntrl_src_arb #(
  parameter int NSRC         = 2,
  parameter int PAT_W        = 2,
  parameter int PAGE_W       = 32,
  parameter int GUARD_CYCLES = 4,
  parameter int DRAIN_MAX    = 1024,
  parameter int RESET_SRC    = 0,
  localparam int SELW        = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [SELW-1:0]         SRC_SEL,
  input  logic [NSRC-1:0]         SRC_MEM_WEN,
  input  logic [NSRC-1:0]         SRC_PATTERN_EN,
  input  logic [NSRC*PAT_W-1:0]   SRC_PATTERN,
  input  logic [NSRC*PAGE_W-1:0]  SRC_WRITE_PAGE_NO,
  input  logic                    CLR_STATUS,
  output logic                    MEM_WEN,
  output logic                    PATTERN_EN,
  output logic [PAT_W-1:0]        PATTERN,
  output logic [PAGE_W-1:0]       WRITE_PAGE_NO,
  output logic [SELW-1:0]         ACTIVE_SRC,
  output logic                    SWITCHING,
  output logic                    SEL_ERR,
  output logic                    DRAIN_TO,
  output logic [15:0]             SWITCH_CNT
);

  localparam int DCW = $clog2(DRAIN_MAX) + 1;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_GUARD} state_e;

  state_e              state_q, state_d;
  logic [SELW-1:0]     active_q, active_d;
  logic [SELW-1:0]     target_q, target_d;
  logic [DCW-1:0]      drain_cnt_q, drain_cnt_d;
  logic [7:0]          guard_cnt_q, guard_cnt_d;
  logic                mem_wen_q, mem_wen_d;
  logic                pattern_en_q, pattern_en_d;
  logic [PAT_W-1:0]    pattern_q, pattern_d;
  logic [PAGE_W-1:0]   page_q, page_d;
  logic                sel_err_q, sel_err_d;
  logic                drain_to_q, drain_to_d;
  logic [15:0]         switch_cnt_q, switch_cnt_d;

  logic sel_valid;
  logic src_busy;
  int   act_idx;

  assign sel_valid = (int'(SRC_SEL) < NSRC);
  assign src_busy  = SRC_MEM_WEN[active_q] | SRC_PATTERN_EN[active_q];

  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    target_d     = target_q;
    drain_cnt_d  = '0;
    guard_cnt_d  = '0;
    sel_err_d    = sel_err_q & ~CLR_STATUS;
    drain_to_d   = drain_to_q & ~CLR_STATUS;
    switch_cnt_d = CLR_STATUS ? 16'd0 : switch_cnt_q;

    if (!sel_valid) sel_err_d = 1'b1;

    case (state_q)
      S_RUN: begin
        if (sel_valid && (SRC_SEL != active_q)) begin
          target_d = SRC_SEL;
          state_d  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        drain_cnt_d = drain_cnt_q + 1'b1;
        if (!src_busy) begin
          state_d = S_GUARD;
        end else if (drain_cnt_q == DCW'(DRAIN_MAX - 1)) begin
          state_d    = S_GUARD;
          drain_to_d = 1'b1;
        end
      end
      S_GUARD: begin
        guard_cnt_d = guard_cnt_q + 1'b1;
        if (guard_cnt_q == 8'(GUARD_CYCLES - 1)) begin
          state_d  = S_RUN;
          active_d = target_q;
          if (switch_cnt_d != 16'hFFFF) switch_cnt_d = switch_cnt_d + 16'd1;
        end
      end
      default: state_d = S_RUN;
    endcase

    // Output mux looks at the next state so the registered outputs line up with GUARD exactly.
    act_idx      = int'(active_d);
    mem_wen_d    = SRC_MEM_WEN[active_d];
    pattern_en_d = SRC_PATTERN_EN[active_d];
    pattern_d    = SRC_PATTERN[act_idx*PAT_W +: PAT_W];
    page_d       = SRC_WRITE_PAGE_NO[act_idx*PAGE_W +: PAGE_W];
    if (state_d == S_GUARD) begin
      mem_wen_d    = 1'b0;
      pattern_en_d = 1'b0;
      pattern_d    = pattern_q;
      page_d       = page_q;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_RUN;
      active_q     <= SELW'(RESET_SRC);
      target_q     <= SELW'(RESET_SRC);
      drain_cnt_q  <= '0;
      guard_cnt_q  <= '0;
      mem_wen_q    <= 1'b0;
      pattern_en_q <= 1'b0;
      pattern_q    <= '0;
      page_q       <= '0;
      sel_err_q    <= 1'b0;
      drain_to_q   <= 1'b0;
      switch_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      target_q     <= target_d;
      drain_cnt_q  <= drain_cnt_d;
      guard_cnt_q  <= guard_cnt_d;
      mem_wen_q    <= mem_wen_d;
      pattern_en_q <= pattern_en_d;
      pattern_q    <= pattern_d;
      page_q       <= page_d;
      sel_err_q    <= sel_err_d;
      drain_to_q   <= drain_to_d;
      switch_cnt_q <= switch_cnt_d;
    end
  end

  assign MEM_WEN       = mem_wen_q;
  assign PATTERN_EN    = pattern_en_q;
  assign PATTERN       = pattern_q;
  assign WRITE_PAGE_NO = page_q;
  assign ACTIVE_SRC    = active_q;
  assign SWITCHING     = (state_q != S_RUN);
  assign SEL_ERR       = sel_err_q;
  assign DRAIN_TO      = drain_to_q;
  assign SWITCH_CNT    = switch_cnt_q;

endmodule
